// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_src;
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } ctrl_t;

  // Whole front end held, MEM/WB gets a bubble while memory is outstanding.
  localparam ctrl_t CTRL_FREEZE = '{pc_src: 1'b0, pc_stall: 1'b1, if_id_stall: 1'b1,
                                    if_id_flush: 1'b0, id_ex_stall: 1'b1, id_ex_flush: 1'b0,
                                    ex_mem_stall: 1'b1, mem_wb_flush: 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, taken-branch redirect and data-memory wait/timeout.
// Handshake: mem_req/mem_ready are level signals; an access completes in any cycle where both are 1.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] id_rs,
  input  logic [REG_IDX_W-1:0] id_rt,
  input  logic                 id_uses_rs,
  input  logic                 id_uses_rt,
  input  logic                 ex_mem_read,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_branch_tkn,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_src,
  output logic                 pc_stall,
  output logic                 if_id_stall,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 id_ex_flush,
  output logic                 ex_mem_stall,
  output logic                 mem_wb_flush,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt,
  output state_t               dbg_state
);

  localparam int CTR_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [CTR_W-1:0] r_ctr;
  logic [CTR_W-1:0] w_ctr_next;
  logic             r_halted;
  logic             w_halt_set;
  logic             w_load_use;
  logic             w_mem_block;
  logic             w_branch_acc;
  ctrl_t            w_ctrl;

  // r0 is hardwired, so a load targeting it can never create a dependency.
  assign w_load_use = ex_mem_read && (ex_rd != '0) &&
                      ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));
  assign w_mem_block = mem_req && !mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RUN;
      r_ctr    <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_ctr   <= w_ctr_next;
      if (w_halt_set) begin
        r_halted <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ctr_next   = r_ctr;
    w_halt_set   = 1'b0;
    case (r_state)
      RUN: begin
        if (w_mem_block) begin
          w_next_state = MEM_WAIT;
          w_ctr_next   = CTR_ONE;
        end
      end
      MEM_WAIT: begin
        if (!w_mem_block) begin
          w_next_state = RUN;
          w_ctr_next   = '0;
        end else if (r_ctr == CTR_LAST) begin
          w_next_state = HALT;
          w_halt_set   = 1'b1;
        end else begin
          w_ctr_next = r_ctr + 1'b1;
        end
      end
      HALT: begin
        w_next_state = HALT;
      end
      default: begin
        w_next_state = RUN;
        w_ctr_next   = '0;
      end
    endcase
  end

  // The release cycle of MEM_WAIT decodes like RUN so a frozen branch/load in EX is not lost.
  always_comb begin
    w_ctrl       = '0;
    w_branch_acc = 1'b0;
    case (r_state)
      RUN, MEM_WAIT: begin
        if (w_mem_block) begin
          w_ctrl = CTRL_FREEZE;
        end else if (ex_branch_tkn) begin
          w_ctrl.pc_src      = 1'b1;
          w_ctrl.if_id_flush = 1'b1;
          w_ctrl.id_ex_flush = 1'b1;
          w_branch_acc       = 1'b1;
        end else if (w_load_use) begin
          w_ctrl.pc_stall    = 1'b1;
          w_ctrl.if_id_stall = 1'b1;
          w_ctrl.id_ex_flush = 1'b1;
        end
      end
      HALT: begin
        w_ctrl = CTRL_FREEZE;
      end
      default: begin
        w_ctrl = '0;
      end
    endcase
    if (rst) begin
      w_ctrl       = '0;
      w_branch_acc = 1'b0;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_ctrl.pc_stall),
    .clear (1'b0),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_branch_acc),
    .clear (1'b0),
    .count (flush_cnt)
  );

  assign pc_src       = w_ctrl.pc_src;
  assign pc_stall     = w_ctrl.pc_stall;
  assign if_id_stall  = w_ctrl.if_id_stall;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_stall  = w_ctrl.id_ex_stall;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign ex_mem_stall = w_ctrl.ex_mem_stall;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign halted       = r_halted;
  assign dbg_state    = r_state;

endmodule
